// File: rtl/key_press_encoder.sv
// Debounced 8-key encoder: 2-flop sync, per-key debounce, lowest-index-wins reporting FSM.
// Optional autorepeat of key_pulse is built only when KEY_AUTOREPEAT_EN is defined.
module key_press_encoder #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_CYCLES   = 8
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] keys_in,
   output logic [2:0] key_played,
   output logic       key_valid,
   output logic       key_pulse
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESSED = 1'b1
   } state_t;

   logic [7:0]       sync1_r;
   logic [7:0]       sync2_r;
   logic [7:0]       stable_r;
   logic [CNT_W-1:0] cnt_r [8];
   state_t           state_r;
   state_t           state_nx_s;
   logic [2:0]       played_nx_s;
   logic             valid_nx_s;
   logic             pulse_nx_s;

`ifdef KEY_AUTOREPEAT_EN
   localparam int REP_W = $clog2(REPEAT_CYCLES);
   localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};
   localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
   logic [REP_W-1:0] rep_cnt_r;
   logic [REP_W-1:0] rep_nx_s;
`endif

   // Parameter sanity check at elaboration
   if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
      $error("key_press_encoder: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
   end

   function automatic logic [2:0] lowest_index(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) begin
            idx = 3'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Synchronizer and per-key debounce counters / stable states
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sync1_r  <= 8'h00;
         sync2_r  <= 8'h00;
         stable_r <= 8'h00;
         for (int i = 0; i < 8; i++) begin
            cnt_r[i] <= CNT_ZERO;
         end
      end else begin
         sync1_r <= keys_in;
         sync2_r <= sync1_r;
         for (int i = 0; i < 8; i++) begin
            if (sync2_r[i] == stable_r[i]) begin
               cnt_r[i] <= CNT_ZERO;
            end else if (cnt_r[i] == CNT_LAST) begin
               cnt_r[i]    <= CNT_ZERO;
               stable_r[i] <= ~stable_r[i];
            end else begin
               cnt_r[i] <= cnt_r[i] + CNT_ONE;
            end
         end
      end
   end

   // Reporting FSM: next state and next registered outputs
   always_comb begin
      state_nx_s  = state_r;
      played_nx_s = key_played;
      valid_nx_s  = 1'b0;
      pulse_nx_s  = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rep_nx_s    = REP_ZERO;
`endif
      case (state_r)
         IDLE: begin
            if (|stable_r) begin
               played_nx_s = lowest_index(stable_r);
               valid_nx_s  = 1'b1;
               pulse_nx_s  = 1'b1;
               state_nx_s  = PRESSED;
            end else begin
               state_nx_s  = IDLE;
            end
         end
         PRESSED: begin
            // Held key stays reported; other keys are ignored until it is released
            if (stable_r[key_played]) begin
               valid_nx_s = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
               if (rep_cnt_r == REP_LAST) begin
                  pulse_nx_s = 1'b1;
                  rep_nx_s   = REP_ZERO;
               end else begin
                  rep_nx_s   = rep_cnt_r + REP_ONE;
               end
`endif
            end else begin
               state_nx_s = IDLE;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_r    <= IDLE;
         key_played <= 3'd0;
         key_valid  <= 1'b0;
         key_pulse  <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
         rep_cnt_r  <= REP_ZERO;
`endif
      end else begin
         state_r    <= state_nx_s;
         key_played <= played_nx_s;
         key_valid  <= valid_nx_s;
         key_pulse  <= pulse_nx_s;
`ifdef KEY_AUTOREPEAT_EN
         rep_cnt_r  <= rep_nx_s;
`endif
      end
   end

endmodule

// File: tb/tb_key_press_encoder.sv
// Scoreboard bench for key_press_encoder (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8).
// Expected pulses (cycle, key) are queued at stimulus time and matched by a monitor.
module tb_key_press_encoder;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic [7:0] keys_in = 8'h00;
   logic [2:0] key_played;
   logic       key_valid;
   logic       key_pulse;

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      int cyc;
      int key;
   } exp_t;
   exp_t exp_q[$];

   key_press_encoder #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .keys_in   (keys_in),
      .key_played(key_played),
      .key_valid (key_valid),
      .key_pulse (key_pulse)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input int c, input int k);
      exp_t e;
      e.cyc = c;
      e.key = k;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic wait_to(input int target);
      while (cyc < target) @(negedge clk_in);
   endtask

   // Pulse monitor: every pulse must match the head of the scoreboard
   always @(negedge clk_in) begin
      if (key_pulse === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_pulse", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq("pulse_cycle", cyc, e.cyc);
            check_eq("pulse_key", int'(key_played), e.key);
            check_eq("pulse_valid", int'(key_valid), 1);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int r;
      int s;

      // Test 1: reset, then single key 3
      rst_in  = 1'b1;
      keys_in = 8'h00;
      tick(2);
      check_eq("rst_played", int'(key_played), 0);
      check_eq("rst_valid", int'(key_valid), 0);
      check_eq("rst_pulse", int'(key_pulse), 0);
      rst_in = 1'b0;
      tick(2);
      t = cyc;
      keys_in = 8'h08;
      push_exp(t + 7, 3);
`ifdef KEY_AUTOREPEAT_EN
      push_exp(t + 15, 3);
      push_exp(t + 23, 3);
`endif
      wait_to(t + 6);
      check_eq("t1_valid_before", int'(key_valid), 0);
      wait_to(t + 8);
      check_eq("t1_played", int'(key_played), 3);
      check_eq("t1_valid_held", int'(key_valid), 1);
      wait_to(t + 20);
      keys_in = 8'h00;
      wait_to(t + 26);
      check_eq("t1_valid_pre_rel", int'(key_valid), 1);
      wait_to(t + 27);
      check_eq("t1_valid_rel", int'(key_valid), 0);
      check_eq("t1_played_kept", int'(key_played), 3);
      tick(4);

      // Test 2: short glitch on key 5
      keys_in = 8'h20;
      tick(3);
      keys_in = 8'h00;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check_eq("t2_valid", int'(key_valid), 0);
         check_eq("t2_pulse", int'(key_pulse), 0);
      end

      // Test 3: simultaneous keys, no preemption, back-to-back hand-over
      t = cyc;
      keys_in = 8'h90;
      push_exp(t + 7, 4);
`ifdef KEY_AUTOREPEAT_EN
      push_exp(t + 15, 4);
      push_exp(t + 23, 4);
`endif
      wait_to(t + 10);
      keys_in = 8'h92;
      wait_to(t + 20);
      check_eq("t3_played_frozen", int'(key_played), 4);
      check_eq("t3_valid", int'(key_valid), 1);
      r = cyc;
      keys_in = 8'h02;
      push_exp(r + 8, 1);
      wait_to(r + 7);
      check_eq("t3_gap_valid", int'(key_valid), 0);
      wait_to(r + 9);
      check_eq("t3_next_played", int'(key_played), 1);
      check_eq("t3_next_valid", int'(key_valid), 1);
      keys_in = 8'h00;
      tick(12);

      // Test 4: reset while key 6 held
      t = cyc;
      keys_in = 8'h40;
      push_exp(t + 7, 6);
      wait_to(t + 10);
      rst_in = 1'b1;
      tick(1);
      check_eq("t4_rst_played", int'(key_played), 0);
      check_eq("t4_rst_valid", int'(key_valid), 0);
      check_eq("t4_rst_pulse", int'(key_pulse), 0);
      rst_in = 1'b0;
      s = cyc;
      push_exp(s + 7, 6);
      wait_to(s + 8);
      check_eq("t4_played", int'(key_played), 6);
      check_eq("t4_valid", int'(key_valid), 1);
      keys_in = 8'h00;
      tick(12);

      // Test 5: key 2 held 30 cycles (autorepeat when enabled)
      t = cyc;
      keys_in = 8'h04;
      push_exp(t + 7, 2);
`ifdef KEY_AUTOREPEAT_EN
      push_exp(t + 15, 2);
      push_exp(t + 23, 2);
      push_exp(t + 31, 2);
`endif
      wait_to(t + 30);
      keys_in = 8'h00;
      wait_to(t + 36);
      check_eq("t5_valid_held", int'(key_valid), 1);
      wait_to(t + 37);
      check_eq("t5_valid_rel", int'(key_valid), 0);
      tick(4);

      // Test 6: key 0 with short dropouts after reporting
      t = cyc;
      keys_in = 8'h01;
      push_exp(t + 7, 0);
`ifdef KEY_AUTOREPEAT_EN
      push_exp(t + 15, 0);
      push_exp(t + 23, 0);
      push_exp(t + 31, 0);
`endif
      wait_to(t + 8);
      for (int i = 0; i < 4; i++) begin
         keys_in = 8'h00;
         tick(1);
         check_eq("t6_valid", int'(key_valid), 1);
         tick(1);
         check_eq("t6_valid", int'(key_valid), 1);
         keys_in = 8'h01;
         for (int j = 0; j < 3; j++) begin
            tick(1);
            check_eq("t6_valid", int'(key_valid), 1);
         end
      end
      keys_in = 8'h00;
      tick(12);
      check_eq("t6_valid_rel", int'(key_valid), 0);

      check_eq("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
